// File: rtl/usb_line_state_det.sv
// rtl/usb_line_state_det.sv - USB bus line-state detector (bus reset, suspend, resume)
// Optional raw-sample glitch filter: define USB_LINE_STATE_GLITCH_FILTER_EN
module usb_line_state_det #(
    parameter int IN_CLK_MHZ = 12,
    parameter int RESET_NS   = 2500,
    parameter int SUSPEND_US = 3000,
    parameter int RESUME_US  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    output logic       usb_reset,
    output logic       suspend,
    output logic       resume,
    output logic [1:0] line_state
);

    localparam int RESET_CYC   = RESET_NS * IN_CLK_MHZ / 1000;
    localparam int SUSPEND_CYC = SUSPEND_US * IN_CLK_MHZ;
    localparam int RESUME_CYC  = RESUME_US * IN_CLK_MHZ;
    localparam int CW          = $clog2(SUSPEND_CYC + 1);

    localparam logic [CW-1:0] RESET_THR   = CW'(RESET_CYC);
    localparam logic [CW-1:0] SUSPEND_THR = CW'(SUSPEND_CYC);
    localparam logic [CW-1:0] RESUME_THR  = CW'(RESUME_CYC);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_BUS_RESET,
        ST_SUSPENDED,
        ST_RESUMING
    } state_t;

    logic [1:0]    raw;
    logic [1:0]    ls_next;
    logic [1:0]    ls_prev;
    logic [CW-1:0] run_cnt;
    state_t        state;
    state_t        state_d;
    logic          se0_hit;
    logic          j_hit;
    logic          k_hit;

    assign raw = {usb_p_rx, usb_n_rx};

`ifdef USB_LINE_STATE_GLITCH_FILTER_EN
    logic [1:0] raw_last;
    logic [1:0] raw_cnt;

    // Count consecutive identical raw samples, saturating at 3
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_last <= LS_SE1;
            raw_cnt  <= 2'd0;
        end else begin
            raw_last <= raw;
            if (raw != raw_last)
                raw_cnt <= 2'd1;
            else if (raw_cnt != 2'd3)
                raw_cnt <= raw_cnt + 2'd1;
        end
    end

    // Accept a raw value on its third identical sample in a row
    always_comb begin
        ls_next = line_state;
        if (raw == raw_last && raw_cnt >= 2'd2)
            ls_next = raw;
    end
`else
    assign ls_next = raw;
`endif

    // Accepted line state register
    always_ff @(posedge clk) begin
        if (reset)
            line_state <= LS_SE1;
        else
            line_state <= ls_next;
    end

    // Run length of line_state, kept one cycle behind alongside ls_prev;
    // saturation at the suspend threshold is the longest run that matters
    always_ff @(posedge clk) begin
        if (reset) begin
            ls_prev <= LS_SE1;
            run_cnt <= '0;
        end else begin
            ls_prev <= line_state;
            if (line_state != ls_prev)
                run_cnt <= CW'(1);
            else if (run_cnt != SUSPEND_THR)
                run_cnt <= run_cnt + CW'(1);
        end
    end

    // Equality hits fire once per run; SE1 never matches any of them
    assign se0_hit = (ls_prev == LS_SE0) && (run_cnt == RESET_THR);
    assign j_hit   = (ls_prev == LS_J)   && (run_cnt == SUSPEND_THR);
    assign k_hit   = (ls_prev == LS_K)   && (run_cnt == RESUME_THR);

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            ST_ACTIVE: begin
                if (se0_hit)
                    state_d = ST_BUS_RESET;
                else if (j_hit)
                    state_d = ST_SUSPENDED;
            end
            ST_BUS_RESET: begin
                if (line_state == LS_J || line_state == LS_K)
                    state_d = ST_ACTIVE;
            end
            ST_SUSPENDED: begin
                if (se0_hit)
                    state_d = ST_BUS_RESET;
                else if (k_hit)
                    state_d = ST_RESUMING;
            end
            ST_RESUMING: begin
                if (line_state == LS_SE0 || line_state == LS_J)
                    state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ACTIVE;
            usb_reset <= 1'b0;
            suspend   <= 1'b0;
            resume    <= 1'b0;
        end else begin
            state     <= state_d;
            usb_reset <= (state_d == ST_BUS_RESET);
            suspend   <= (state_d == ST_SUSPENDED) || (state_d == ST_RESUMING);
            resume    <= (state == ST_SUSPENDED) && (state_d == ST_RESUMING);
        end
    end

endmodule

// File: tb/tb_usb_line_state_det.sv
// tb/tb_usb_line_state_det.sv - scoreboard bench for usb_line_state_det
module tb_usb_line_state_det;

    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE1 = 2'b11;

`ifdef USB_LINE_STATE_GLITCH_FILTER_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam int L = 1 + D;

    logic       clk = 1'b0;
    logic       reset;
    logic       usb_p_rx;
    logic       usb_n_rx;
    logic       usb_reset;
    logic       suspend;
    logic       resume;
    logic [1:0] line_state;

    int         checks = 0;
    int         fails  = 0;
    logic [4:0] exp_q[$];
    logic [4:0] e;
    logic [4:0] obs;

    usb_line_state_det dut (
        .clk        (clk),
        .reset      (reset),
        .usb_p_rx   (usb_p_rx),
        .usb_n_rx   (usb_n_rx),
        .usb_reset  (usb_reset),
        .suspend    (suspend),
        .resume     (resume),
        .line_state (line_state)
    );

    always #5 clk = ~clk;

    // drive one line value for one edge, queue the expected {usb_reset,suspend,resume,line_state}
    task automatic drive(input logic [1:0] ln, input logic [4:0] ex);
        usb_p_rx = ln[1];
        usb_n_rx = ln[0];
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        usb_p_rx = 1'b0;
        usb_n_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        usb_p_rx = 1'b0;
        usb_n_rx = 1'b0;
        exp_q.push_back(5'b00011);
        repeat (3) @(posedge clk);
        #1;
        obs = {usb_reset, suspend, resume, line_state};
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin fails++; $display("FAIL reset_state got %b want %b", obs, e); end
        reset = 1'b0;
    endtask

    task automatic test_se0_reset();
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            drive(SE0, {(k >= 32 + D), 1'b0, 1'b0, (k >= L) ? SE0 : SE1});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL se0_rise k=%0d got %b want %b", k, obs, e); end
        end
        for (int j = 1; j <= 6; j++) begin
            drive(J, {(j < 2 + D), 1'b0, 1'b0, (j >= L) ? J : SE0});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL se0_fall j=%0d got %b want %b", j, obs, e); end
        end
    endtask

    task automatic test_se0_short();
        do_reset();
        for (int k = 1; k <= 29; k++) begin
            drive(SE0, {1'b0, 1'b0, 1'b0, (k >= L) ? SE0 : SE1});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL se0_29 k=%0d got %b want %b", k, obs, e); end
        end
        for (int j = 1; j <= 10; j++) begin
            drive(J, {1'b0, 1'b0, 1'b0, (j >= L) ? J : SE0});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL se0_29_j j=%0d got %b want %b", j, obs, e); end
        end
    endtask

    task automatic test_se0_boundary();
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            drive(SE0, {1'b0, 1'b0, 1'b0, (k >= L) ? SE0 : SE1});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL se0_30 k=%0d got %b want %b", k, obs, e); end
        end
        for (int j = 1; j <= 8; j++) begin
            drive(J, {(j == 2 + D), 1'b0, 1'b0, (j >= L) ? J : SE0});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL se0_30_j j=%0d got %b want %b", j, obs, e); end
        end
    endtask

    task automatic test_suspend_resume();
        logic [1:0] ln;
        logic [1:0] ls;
        do_reset();
        for (int k = 1; k <= 36010; k++) begin
            drive(J, {1'b0, (k >= 36002 + D), 1'b0, (k >= L) ? J : SE1});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL suspend_j k=%0d got %b want %b", k, obs, e); end
        end
        for (int m = 1; m <= 130; m++) begin
            ln = (m <= 120) ? K : SE0;
            ls = (m < L) ? J : ((m < 120 + L) ? K : SE0);
            drive(ln, {1'b0, (m < 123 + D), (m == 122 + D), ls});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL resume m=%0d got %b want %b", m, obs, e); end
        end
    endtask

    task automatic test_suspend_to_reset();
        do_reset();
        for (int k = 1; k <= 36010; k++) begin
            drive(J, {1'b0, (k >= 36002 + D), 1'b0, (k >= L) ? J : SE1});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL susp2_j k=%0d got %b want %b", k, obs, e); end
        end
        for (int s = 1; s <= 36; s++) begin
            drive(SE0, {(s >= 32 + D), (s < 32 + D), 1'b0, (s >= L) ? SE0 : J});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL susp_to_reset s=%0d got %b want %b", s, obs, e); end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] ln;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            ln = ((k % 20) == 10 || (k % 20) == 11) ? J : SE0;
`ifdef USB_LINE_STATE_GLITCH_FILTER_EN
            drive(ln, {(k >= 34), 1'b0, 1'b0, (k >= 3) ? SE0 : SE1});
`else
            drive(ln, {1'b0, 1'b0, 1'b0, ln});
`endif
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL glitch k=%0d got %b want %b", k, obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            drive(SE0, {1'b0, 1'b0, 1'b0, (k >= L) ? SE0 : SE1});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL mid_pre k=%0d got %b want %b", k, obs, e); end
        end
        reset = 1'b1;
        for (int r = 1; r <= 2; r++) begin
            drive(SE0, 5'b00011);
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL mid_in_reset r=%0d got %b want %b", r, obs, e); end
        end
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            drive(SE0, {(k >= 32 + D), 1'b0, 1'b0, (k >= L) ? SE0 : SE1});
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL mid_post k=%0d got %b want %b", k, obs, e); end
        end
    endtask

    task automatic test_se1();
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            drive(SE1, 5'b00011);
            obs = {usb_reset, suspend, resume, line_state};
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin fails++; $display("FAIL se1 k=%0d got %b want %b", k, obs, e); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        usb_p_rx = 1'b0;
        usb_n_rx = 1'b0;
        test_reset();
        test_se0_reset();
        test_se0_short();
        test_se0_boundary();
        test_glitch();
        test_reset_mid();
        test_se1();
        test_suspend_resume();
        test_suspend_to_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
